// File: rtl/sequenciador_execucao.sv
// Multicycle step sequencer for the 16-bit processor: owns the
// step counter and turns decoded fields into datapath controls.
//
// Inputs : Clock, Resetn (async, active low), Run,
//          OpSelect, Rx, Ry, Imediato.
// Outputs: Contador/Clear (step counter and clear to the decoder),
//          IRin, Rin/Rout (one-hot), DINout, ImmExt, Ain, Gin, Gout,
//          AluOp, OUTin, Done, Busy, IllegalOp (sticky).
module sequenciador_execucao #(
  parameter int NREGS  = 8,
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [2:0]        OpSelect,
  input  logic [2:0]        Rx,
  input  logic [2:0]        Ry,
  input  logic [9:0]        Imediato,
  output logic [1:0]        Contador,
  output logic              Clear,
  output logic              IRin,
  output logic [NREGS-1:0]  Rin,
  output logic [NREGS-1:0]  Rout,
  output logic              DINout,
  output logic [DATA_W-1:0] ImmExt,
  output logic              Ain,
  output logic              Gin,
  output logic              Gout,
  output logic [1:0]        AluOp,
  output logic              OUTin,
  output logic              Done,
  output logic              Busy,
  output logic              IllegalOp
);

  logic [1:0] cnt_q, cnt_d;
  logic       ill_q, ill_d;
  logic       fin;
  logic       set_ill;

  logic is_alu, is_out, is_ldi, is_rep;
  logic [NREGS-1:0] rx_oh, ry_oh;

  assign is_alu = (OpSelect == 3'b000) ||
                  (OpSelect == 3'b001) ||
                  (OpSelect == 3'b010);
  assign is_out = (OpSelect == 3'b011);
  assign is_ldi = (OpSelect == 3'b101);
  assign is_rep = (OpSelect == 3'b111);

  assign rx_oh = {{(NREGS-1){1'b0}}, 1'b1} << Rx;
  assign ry_oh = {{(NREGS-1){1'b0}}, 1'b1} << Ry;

  assign ImmExt = {{(DATA_W-10){1'b0}}, Imediato};

  // Everything is gated by Resetn so that no enable (even IRin
  // from Run) escapes while the block is held in reset.
  always_comb begin
    IRin    = 1'b0;
    Rin     = '0;
    Rout    = '0;
    DINout  = 1'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    Gout    = 1'b0;
    AluOp   = 2'b00;
    OUTin   = 1'b0;
    fin     = 1'b0;
    set_ill = 1'b0;
    if (Resetn) begin
      unique case (cnt_q)
        2'd0: IRin = Run;
        2'd1: begin
          unique case (1'b1)
            is_alu: begin
              Rout = rx_oh;
              Ain  = 1'b1;
            end
            is_ldi: begin
              DINout = 1'b1;
              Rin    = rx_oh;
              fin    = 1'b1;
            end
            is_rep: begin
              Rout = ry_oh;
              Rin  = rx_oh;
              fin  = 1'b1;
            end
            is_out: begin
              Rout  = rx_oh;
              OUTin = 1'b1;
              fin   = 1'b1;
            end
            default: begin
              fin     = 1'b1;
              set_ill = 1'b1;
            end
          endcase
        end
        2'd2: begin
          if (is_alu) begin
            Rout  = ry_oh;
            Gin   = 1'b1;
            AluOp = OpSelect[1:0];
          end
        end
        2'd3: begin
          // Step 3 always clears, so the counter can never wrap.
          fin = 1'b1;
          if (is_alu) begin
            Gout = 1'b1;
            Rin  = rx_oh;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (fin)
      cnt_d = 2'd0;
    else if (cnt_q != 2'd0 || Run)
      cnt_d = cnt_q + 2'd1;
  end

  assign ill_d = ill_q | set_ill;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q <= 2'd0;
      ill_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ill_q <= ill_d;
    end
  end

  assign Contador  = cnt_q;
  assign Clear     = fin;
  assign Done      = fin;
  assign Busy      = Resetn && (cnt_q != 2'd0);
  assign IllegalOp = ill_q;

endmodule

// File: tb/tb_sequenciador_execucao.sv
// Directed self-checking bench for sequenciador_execucao.
// Inputs change 1ns after a rising edge; outputs checked 1ns later.
module tb_sequenciador_execucao;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Run;
  logic [2:0]  OpSelect, Rx, Ry;
  logic [9:0]  Imediato;
  logic [1:0]  Contador;
  logic        Clear, IRin, DINout, Ain, Gin, Gout;
  logic [7:0]  Rin, Rout;
  logic [15:0] ImmExt;
  logic [1:0]  AluOp;
  logic        OUTin, Done, Busy, IllegalOp;

  int checks = 0;
  int failures = 0;

  sequenciador_execucao #(.NREGS(8), .DATA_W(16)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run),
    .OpSelect(OpSelect), .Rx(Rx), .Ry(Ry), .Imediato(Imediato),
    .Contador(Contador), .Clear(Clear), .IRin(IRin),
    .Rin(Rin), .Rout(Rout), .DINout(DINout), .ImmExt(ImmExt),
    .Ain(Ain), .Gin(Gin), .Gout(Gout), .AluOp(AluOp),
    .OUTin(OUTin), .Done(Done), .Busy(Busy),
    .IllegalOp(IllegalOp)
  );

  always #5 Clock = ~Clock;

  logic [28:0] obs;
  assign obs = {Contador, Clear, IRin, Rin, Rout, DINout, Ain,
                Gin, Gout, AluOp, OUTin, Done, Busy};

  // Expected control vector; fin drives both Clear and Done,
  // busy is Contador!=0 (zero while in reset since Contador is 0).
  function automatic logic [28:0] mk(
    input logic [1:0] c, input logic ir,
    input logic [7:0] rin, input logic [7:0] rout,
    input logic din, input logic ain, input logic gin,
    input logic gout, input logic [1:0] alu,
    input logic outin, input logic fin);
    mk = {c, fin, ir, rin, rout, din, ain, gin, gout, alu,
          outin, fin, (c != 2'd0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  localparam logic [7:0] Z = 8'h00;

  initial begin
    Resetn = 1'b0; Run = 1'b0; OpSelect = 3'b000;
    Rx = 3'd0; Ry = 3'd0; Imediato = 10'h000;
    step();
    // 1. Reset forces all controls low, ImmExt still follows.
    Run = 1'b1; Imediato = 10'h155;
    OpSelect = 3'b000; Rx = 3'd2; Ry = 3'd5;
    settle();
    chk("rst_ctl", 32'(obs), 32'(mk(0,0,Z,Z,0,0,0,0,0,0,0)));
    chk("rst_ill", 32'(IllegalOp), 32'(0));
    chk("rst_imm", 32'(ImmExt), 32'h0155);
    step();
    Resetn = 1'b1;
    settle();
    chk("add0_T0", 32'(obs), 32'(mk(0,1,Z,Z,0,0,0,0,0,0,0)));
    step();
    Run = 1'b0;
    settle();
    chk("add0_T1", 32'(obs),
        32'(mk(1,0,Z,8'b00000100,0,1,0,0,0,0,0)));
    step();
    settle();
    chk("add0_T2", 32'(obs),
        32'(mk(2,0,Z,8'b00100000,0,0,1,0,2'b00,0,0)));
    Resetn = 1'b0;
    settle();
    chk("midrst", 32'(obs), 32'(mk(0,0,Z,Z,0,0,0,0,0,0,0)));
    step();
    Resetn = 1'b1; Run = 1'b0;
    settle();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle", 32'(obs), 32'(mk(0,0,Z,Z,0,0,0,0,0,0,0)));
    end

    // 2. ldi r3, 0x2A5
    Run = 1'b1; OpSelect = 3'b101; Rx = 3'd3; Imediato = 10'h2A5;
    settle();
    chk("ldi_T0", 32'(obs), 32'(mk(0,1,Z,Z,0,0,0,0,0,0,0)));
    step();
    Run = 1'b0;
    settle();
    chk("ldi_T1", 32'(obs),
        32'(mk(1,0,8'b00001000,Z,1,0,0,0,0,0,1)));
    chk("ldi_imm", 32'(ImmExt), 32'h02A5);
    step();
    chk("ldi_end", 32'(obs), 32'(mk(0,0,Z,Z,0,0,0,0,0,0,0)));

    // 3 + 5. add/sub/nand r2,r5; Run toggled while busy on sub.
    for (int i = 0; i < 3; i++) begin
      Run = 1'b1; OpSelect = 3'(i); Rx = 3'd2; Ry = 3'd5;
      settle();
      chk("alu_T0", 32'(obs), 32'(mk(0,1,Z,Z,0,0,0,0,0,0,0)));
      step();
      Run = (i == 1);
      settle();
      chk("alu_T1", 32'(obs),
          32'(mk(1,0,Z,8'b00000100,0,1,0,0,0,0,0)));
      step();
      Run = 1'b0;
      settle();
      chk("alu_T2", 32'(obs),
          32'(mk(2,0,Z,8'b00100000,0,0,1,0,2'(i),0,0)));
      step();
      Run = (i == 1);
      settle();
      chk("alu_T3", 32'(obs),
          32'(mk(3,0,8'b00000100,Z,0,0,0,1,0,0,1)));
      step();
      Run = 1'b0;
      settle();
      chk("alu_end", 32'(obs), 32'(mk(0,0,Z,Z,0,0,0,0,0,0,0)));
    end

    // 4. Back-to-back rep r1,r7 then out r4 with Run held.
    Run = 1'b1; OpSelect = 3'b111; Rx = 3'd1; Ry = 3'd7;
    settle();
    chk("rep_T0", 32'(obs), 32'(mk(0,1,Z,Z,0,0,0,0,0,0,0)));
    step();
    chk("rep_T1", 32'(obs),
        32'(mk(1,0,8'b00000010,8'b10000000,0,0,0,0,0,0,1)));
    step();
    OpSelect = 3'b011; Rx = 3'd4;
    settle();
    chk("out_T0", 32'(obs), 32'(mk(0,1,Z,Z,0,0,0,0,0,0,0)));
    step();
    chk("out_T1", 32'(obs),
        32'(mk(1,0,Z,8'b00010000,0,0,0,0,0,1,1)));
    step();
    Run = 1'b0;
    settle();
    chk("b2b_end", 32'(obs), 32'(mk(0,0,Z,Z,0,0,0,0,0,0,0)));

    // 6. Reserved opcode sets sticky IllegalOp.
    Run = 1'b1; OpSelect = 3'b110;
    settle();
    chk("rsv_T0", 32'(obs), 32'(mk(0,1,Z,Z,0,0,0,0,0,0,0)));
    step();
    Run = 1'b0;
    settle();
    chk("rsv_T1", 32'(obs), 32'(mk(1,0,Z,Z,0,0,0,0,0,0,1)));
    chk("rsv_ill0", 32'(IllegalOp), 32'(0));
    step();
    chk("rsv_ill1", 32'(IllegalOp), 32'(1));
    chk("rsv_end", 32'(obs), 32'(mk(0,0,Z,Z,0,0,0,0,0,0,0)));
    Run = 1'b1; OpSelect = 3'b101; Rx = 3'd0; Imediato = 10'h3FF;
    step();
    Run = 1'b0;
    settle();
    chk("ldi2_T1", 32'(obs),
        32'(mk(1,0,8'b00000001,Z,1,0,0,0,0,0,1)));
    chk("ldi2_imm", 32'(ImmExt), 32'h03FF);
    step();
    chk("ill_stay", 32'(IllegalOp), 32'(1));
    Run = 1'b1; OpSelect = 3'b100;
    step();
    Run = 1'b0;
    settle();
    chk("rsv4_T1", 32'(obs), 32'(mk(1,0,Z,Z,0,0,0,0,0,0,1)));
    step();
    Resetn = 1'b0;
    settle();
    chk("ill_clr", 32'(IllegalOp), 32'(0));
    step();
    Resetn = 1'b1;
    step();
    chk("ill_after", 32'(IllegalOp), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
